proc_control_fsm: RTL and testbench
===================================

// Module: proc_control_fsm
// PURPOSE
//  Moore control unit that sequences the processor datapath: PC, IR, data memory, register file and ALU.
//  Fetches each 16-bit instruction, decodes IR[15:12] and drives every datapath enable, address and select for execution.
//  State and NextState are exported for the board-level debug mux.
//  Sits inside the processor between the debounced step clock and the datapath.
// PARAMETERS
//  DADDR_W  8  data-memory address width (taken from IR fields)
//  RADDR_W  4  register-file address width
// PORTS
//  Clk        in   1        step clock (filtered KEY), all state changes on rising edge
//  Reset      in   1        synchronous, active-high; sampled on rising Clk
//  IR         in   16       current instruction register contents
//  PC_Clr     out  1        clear PC to 0
//  PC_Up      out  1        increment PC
//  IR_Ld      out  1        load IR from instruction memory at PC
//  D_Addr     out  DADDR_W  data-memory address
//  D_Wr       out  1        data-memory write enable
//  RF_s       out  1        RF write-data select: 1 = memory read data, 0 = ALU result
//  RF_W_addr  out  RADDR_W  RF write address
//  RF_W_en    out  1        RF write enable
//  RF_Ra_addr out  RADDR_W  RF read port A address
//  RF_Rb_addr out  RADDR_W  RF read port B address
//  ALU_s0     out  3        ALU op: 0 = pass A, 1 = A+B, 2 = A-B
//  State      out  4        current state code
//  NextState  out  4        next state code (combinational)
// BEHAVIOUR
//  - State codes: Init=0, Fetch=1, Decode=2, NoOp=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9.
//  - Reset=1 at an edge forces State to Init, from any state, including mid-instruction. NextState reads Init while Reset=1.
//  - All outputs are decoded from State and IR only. Every output defaults to 0 unless listed below.
//  - Init: PC_Clr=1. Next state is Fetch.
//  - Fetch: IR_Ld=1, PC_Up=1. IR and PC update on the exit edge. Next state is Decode.
//  - Decode: no enables. Branches on IR[15:12]:
//      0000 -> NoOp; 0001 -> Store; 0010 -> LoadA; 0011 -> Add; 0100 -> Sub; 0101 -> Halt; any other opcode -> NoOp.
//  - NoOp: no enables. Next state is Fetch.
//  - LoadA: D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]. No write yet; this state covers the 1-cycle synchronous memory read.
//    Next state is LoadB.
//  - LoadB: same D_Addr, RF_s and RF_W_addr as LoadA, plus RF_W_en=1. Next state is Fetch.
//  - Store: D_Addr=IR[7:0], RF_Ra_addr=IR[11:8], ALU_s0=0, D_Wr=1. Next state is Fetch.
//  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], ALU_s0=1, RF_s=0, RF_W_en=1. Next state is Fetch.
//  - Sub: same fields as Add, with ALU_s0=2.
//  - Halt: no enables. Stays in Halt until Reset.
//  - Cycle counts from Fetch to the next Fetch: NOOP/STORE/ADD/SUB = 3, LOAD = 4.
//  - Address fields are taken directly from IR with no arithmetic.
//  - Write enables (D_Wr, RF_W_en) are asserted for exactly one cycle per instruction.
//  - No glitch-free guarantee is given on NextState. State is registered.
//  - Unused state codes 10-15 go to Init on the next edge.
// TESTING
//  1. Hold Reset 2 edges, then release -> State=0 with PC_Clr=1. Next edge: State=1 with IR_Ld=1 and PC_Up=1.
//  2. IR=16'h3125 (ADD) -> Decode then Add state with Ra=1, Rb=2, W_addr=5, ALU_s0=1, RF_W_en=1 for 1 cycle.
//     Back in Fetch after 3 edges.
//  3. IR=16'h21A3 (LOAD) -> LoadA with D_Addr=8'h1A and RF_W_en=0. Then LoadB with RF_W_en=1, W_addr=3, RF_s=1.
//     Back in Fetch after 4 edges.
//  4. IR=16'h1740 (STORE) -> D_Addr=8'h40, Ra=7, D_Wr=1 for exactly 1 cycle, no RF_W_en.
//  5. IR=16'h5000 (HALT) -> State=9 holds for 20 edges with all enables 0. Reset -> Init.
//  6. Assert Reset while in LoadA with IR=16'hF000 -> next edge State=0 with no RF_W_en pulse.
//     After release: Fetch, Decode, then NoOp for opcode F.

Source files
------------

// File: rtl/proc_control_fsm_if.sv
// proc_control_fsm_if: instruction in, datapath controls and debug state out.
// The controller uses the master modport; the datapath side uses slave.
interface proc_control_fsm_if #(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
);
    logic [15:0]        IR;
    logic               PC_Clr;
    logic               PC_Up;
    logic               IR_Ld;
    logic [DADDR_W-1:0] D_Addr;
    logic               D_Wr;
    logic               RF_s;
    logic [RADDR_W-1:0] RF_W_addr;
    logic               RF_W_en;
    logic [RADDR_W-1:0] RF_Ra_addr;
    logic [RADDR_W-1:0] RF_Rb_addr;
    logic [2:0]         ALU_s0;
    logic [3:0]         State;
    logic [3:0]         NextState;

    modport master (
        input  IR,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState
    );
    modport slave (
        output IR,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState
    );
endinterface

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: Moore controller sequencing fetch/decode/execute of 16-bit instructions.
// Outputs decode from the registered state and IR; NextState is exported for debug.
module proc_control_fsm #(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    proc_control_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_FETCH = 4'd1,
        S_DEC   = 4'd2,
        S_NOOP  = 4'd3,
        S_LOADA = 4'd4,
        S_LOADB = 4'd5,
        S_STORE = 4'd6,
        S_ADD   = 4'd7,
        S_SUB   = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_dec;
    logic   w_ld;
    logic   w_alu;

    always_comb begin
        w_dec = S_NOOP;
        case (bus.IR[15:12])
            4'h1:    w_dec = S_STORE;
            4'h2:    w_dec = S_LOADA;
            4'h3:    w_dec = S_ADD;
            4'h4:    w_dec = S_SUB;
            4'h5:    w_dec = S_HALT;
            default: w_dec = S_NOOP;
        endcase
    end

    // Unused codes 10-15 fall to Init via the default arm.
    always_comb begin
        w_next = S_INIT;
        case (r_state)
            S_INIT:  w_next = S_FETCH;
            S_FETCH: w_next = S_DEC;
            S_DEC:   w_next = w_dec;
            S_LOADA: w_next = S_LOADB;
            S_HALT:  w_next = S_HALT;
            S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB: w_next = S_FETCH;
            default: w_next = S_INIT;
        endcase
        if (Reset)
            w_next = S_INIT;
    end

    always_ff @(posedge Clk)
        r_state <= Reset ? S_INIT : w_next;

    assign w_ld  = (r_state == S_LOADA) || (r_state == S_LOADB);
    assign w_alu = (r_state == S_ADD) || (r_state == S_SUB);

    assign bus.PC_Clr     = r_state == S_INIT;
    assign bus.PC_Up      = r_state == S_FETCH;
    assign bus.IR_Ld      = r_state == S_FETCH;
    assign bus.D_Wr       = r_state == S_STORE;
    assign bus.RF_s       = w_ld;
    assign bus.RF_W_en    = (r_state == S_LOADB) || w_alu;
    assign bus.D_Addr     = w_ld ? DADDR_W'(bus.IR[11:4]) :
                            (r_state == S_STORE) ? DADDR_W'(bus.IR[7:0]) : '0;
    assign bus.RF_W_addr  = (w_ld || w_alu) ? RADDR_W'(bus.IR[3:0]) : '0;
    assign bus.RF_Ra_addr = (w_alu || r_state == S_STORE) ? RADDR_W'(bus.IR[11:8]) : '0;
    assign bus.RF_Rb_addr = w_alu ? RADDR_W'(bus.IR[7:4]) : '0;
    assign bus.ALU_s0     = (r_state == S_ADD) ? 3'd1 : (r_state == S_SUB) ? 3'd2 : 3'd0;
    assign bus.State      = r_state;
    assign bus.NextState  = w_next;
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: table of per-cycle vectors plus hand sequences for halt and mid-load reset.
module tb_proc_control_fsm;
    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad = 0;

    proc_control_fsm_if bus ();
    proc_control_fsm dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic [3:0]  st;
        logic [3:0]  nx;
        logic [28:0] o;
    } vec_t;

    vec_t tv[$];

    // {PC_Clr,PC_Up,IR_Ld,D_Wr,RF_s,RF_W_en,D_Addr,RF_W_addr,Ra,Rb,ALU_s0}
    function automatic logic [28:0] ex(bit clr, bit up, bit ld, bit dwr, bit rfs, bit wen,
                                       logic [7:0] da, logic [3:0] wa, logic [3:0] ra,
                                       logic [3:0] rb, logic [2:0] alu);
        return {clr, up, ld, dwr, rfs, wen, da, wa, ra, rb, alu};
    endfunction

    function automatic vec_t v(logic [15:0] ir, logic [3:0] st, logic [3:0] nx, logic [28:0] o);
        vec_t t;
        t.rst = 1'b0; t.ir = ir; t.st = st; t.nx = nx; t.o = o;
        return t;
    endfunction

    function automatic logic [28:0] act();
        return {bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Wr, bus.RF_s, bus.RF_W_en,
                bus.D_Addr, bus.RF_W_addr, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0};
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic chk_all(string n, logic [3:0] st, logic [3:0] nx, logic [28:0] o);
        chk({n, ".state"}, 32'(bus.State), 32'(st));
        chk({n, ".next"}, 32'(bus.NextState), 32'(nx));
        chk({n, ".outs"}, 32'(act()), 32'(o));
    endtask

    logic [28:0] o_none, o_init, o_fetch;

    initial begin
        o_none  = '0;
        o_init  = ex(1, 0, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0);
        o_fetch = ex(0, 1, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0);
        // ADD 3125
        tv.push_back(v(16'h3125, 4'd0, 4'd1, o_init));
        tv.push_back(v(16'h3125, 4'd1, 4'd2, o_fetch));
        tv.push_back(v(16'h3125, 4'd2, 4'd7, o_none));
        tv.push_back(v(16'h3125, 4'd7, 4'd1, ex(0, 0, 0, 0, 0, 1, 8'h00, 4'h5, 4'h1, 4'h2, 3'd1)));
        // LOAD 21A3
        tv.push_back(v(16'h21A3, 4'd1, 4'd2, o_fetch));
        tv.push_back(v(16'h21A3, 4'd2, 4'd4, o_none));
        tv.push_back(v(16'h21A3, 4'd4, 4'd5, ex(0, 0, 0, 0, 1, 0, 8'h1A, 4'h3, 4'h0, 4'h0, 3'd0)));
        tv.push_back(v(16'h21A3, 4'd5, 4'd1, ex(0, 0, 0, 0, 1, 1, 8'h1A, 4'h3, 4'h0, 4'h0, 3'd0)));
        // STORE 1740
        tv.push_back(v(16'h1740, 4'd1, 4'd2, o_fetch));
        tv.push_back(v(16'h1740, 4'd2, 4'd6, o_none));
        tv.push_back(v(16'h1740, 4'd6, 4'd1, ex(0, 0, 0, 1, 0, 0, 8'h40, 4'h0, 4'h7, 4'h0, 3'd0)));
        // NOOP 0000
        tv.push_back(v(16'h0000, 4'd1, 4'd2, o_fetch));
        tv.push_back(v(16'h0000, 4'd2, 4'd3, o_none));
        tv.push_back(v(16'h0000, 4'd3, 4'd1, o_none));
        // SUB 4A5C
        tv.push_back(v(16'h4A5C, 4'd1, 4'd2, o_fetch));
        tv.push_back(v(16'h4A5C, 4'd2, 4'd8, o_none));
        tv.push_back(v(16'h4A5C, 4'd8, 4'd1, ex(0, 0, 0, 0, 0, 1, 8'h00, 4'hC, 4'hA, 4'h5, 3'd2)));
        // undefined opcode 7 acts as NOOP
        tv.push_back(v(16'h7000, 4'd1, 4'd2, o_fetch));
        tv.push_back(v(16'h7000, 4'd2, 4'd3, o_none));
        tv.push_back(v(16'h7000, 4'd3, 4'd1, o_none));
        // HALT 5000
        tv.push_back(v(16'h5000, 4'd1, 4'd2, o_fetch));
        tv.push_back(v(16'h5000, 4'd2, 4'd9, o_none));
        tv.push_back(v(16'h5000, 4'd9, 4'd9, o_none));

        bus.IR = 16'h0000;
        Reset  = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk); #1;
        chk_all("reset", 4'd0, 4'd0, o_init);

        foreach (tv[i]) begin
            @(negedge Clk);
            Reset  = tv[i].rst;
            bus.IR = tv[i].ir;
            #1;
            chk_all($sformatf("vec%0d", i), tv[i].st, tv[i].nx, tv[i].o);
        end

        for (int k = 0; k < 20; k++) begin
            @(negedge Clk); #1;
            chk($sformatf("halt%0d.state", k), 32'(bus.State), 32'd9);
            chk($sformatf("halt%0d.outs", k), 32'(act()), 32'(o_none));
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("halt_rst.next", 32'(bus.NextState), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk_all("halt_exit", 4'd0, 4'd1, o_init);

        bus.IR = 16'h21A3;
        @(negedge Clk); #1;
        chk("mid.fetch", 32'(bus.State), 32'd1);
        @(negedge Clk); #1;
        chk_all("mid.dec", 4'd2, 4'd4, o_none);
        @(negedge Clk); #1;
        chk("mid.loada", 32'(bus.State), 32'd4);
        bus.IR = 16'hF000;
        Reset  = 1'b1;
        #1;
        chk_all("mid.loada_rst", 4'd4, 4'd0, ex(0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0));
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk_all("mid.init", 4'd0, 4'd1, o_init);
        @(negedge Clk); #1;
        chk_all("mid.fetch2", 4'd1, 4'd2, o_fetch);
        @(negedge Clk); #1;
        chk_all("mid.dec2", 4'd2, 4'd3, o_none);
        @(negedge Clk); #1;
        chk_all("mid.noop", 4'd3, 4'd1, o_none);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
